// File: rtl/efuse_macro_model.sv
// ---------------------------------------------------------------------------
// efuse_macro_model
//   Behavioural-but-synthesizable model of a 32x8 one-time-programmable eFuse
//   macro. The fuse controller selects programme or read mode and then issues
//   one access per high pulse on efuse_aen_i. The model checks that each pulse
//   is long enough, blows or reads the addressed fuse, and records misuse in
//   sticky error flags.
//
//   Access protocol: efuse_aen_i is a level strobe, not a valid/ready
//   handshake. Each rising edge seen in IDLE starts one access. The access
//   completes on the falling edge, or it is aborted early if the mode select
//   drops while the strobe is still high. No back-pressure exists; busy_o only
//   reports that an access is in flight.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   efuse_pgmen_i     programme-mode select
//   efuse_rden_i      read-mode select
//   efuse_aen_i       access strobe (one access per high pulse)
//   efuse_addr_i      [7:3] byte index, [2:0] bit index within the byte
//   cfg_tpgm_min      minimum strobe-high cycles for a valid programme
//   cfg_trd_min       minimum strobe-high cycles for a valid read
//   efuse_rdata_o     byte returned by the last completed read
//   fuse_bits_o       full array image, bit n = byte n/8, bit n%8
//   err_o             sticky: [0] pgm_short [1] rd_short [2] mode_conflict
//                     [3] mode_drop
//   pgm_cnt_o         number of fuses newly blown, saturating at 256
//   busy_o            high while an access is in progress (PGM or RD)
//   dbg_state_o       current FSM state (0 IDLE, 1 PGM, 2 RD)
// ---------------------------------------------------------------------------
module efuse_macro_model #(
  parameter int TPGM_W = 10,
  parameter int TRD_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              efuse_pgmen_i,
  input  logic              efuse_rden_i,
  input  logic              efuse_aen_i,
  input  logic [7:0]        efuse_addr_i,
  input  logic [TPGM_W-1:0] cfg_tpgm_min,
  input  logic [TRD_W-1:0]  cfg_trd_min,
  output logic [7:0]        efuse_rdata_o,
  output logic [255:0]      fuse_bits_o,
  output logic [3:0]        err_o,
  output logic [8:0]        pgm_cnt_o,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  // The width counter must be able to reach either threshold.
  localparam int CNT_W = (TPGM_W > TRD_W) ? TPGM_W : TRD_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PGM  = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t           state;
  logic             aen_q;
  logic             rise_block;
  logic [7:0]       addr_q;
  logic [CNT_W-1:0] width_cnt;

  logic             aen_rise;
  logic             cnt_sat;
  logic [CNT_W-1:0] tpgm_ext;
  logic [CNT_W-1:0] trd_ext;

  // rise_block is set by reset and cleared only once the strobe is seen low,
  // so a strobe held high across reset release never starts an access.
  assign aen_rise = efuse_aen_i & ~aen_q & ~rise_block;
  assign cnt_sat  = &width_cnt;
  assign tpgm_ext = CNT_W'(cfg_tpgm_min);
  assign trd_ext  = CNT_W'(cfg_trd_min);

  assign busy_o      = (state == S_PGM) || (state == S_RD);
  assign dbg_state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      aen_q         <= 1'b0;
      rise_block    <= 1'b1;
      addr_q        <= 8'h00;
      width_cnt     <= '0;
      efuse_rdata_o <= 8'h00;
      fuse_bits_o   <= '0;
      err_o         <= 4'h0;
      pgm_cnt_o     <= 9'd0;
    end else begin
      aen_q <= efuse_aen_i;
      if (!efuse_aen_i) rise_block <= 1'b0;

      case (state)
        S_IDLE: begin
          if (aen_rise) begin
            if (efuse_pgmen_i && !efuse_rden_i) begin
              state     <= S_PGM;
              addr_q    <= efuse_addr_i;
              width_cnt <= CNT_W'(1);
            end else if (efuse_rden_i && !efuse_pgmen_i) begin
              state     <= S_RD;
              addr_q    <= efuse_addr_i;
              width_cnt <= CNT_W'(1);
            end else if (efuse_pgmen_i && efuse_rden_i) begin
              err_o[2] <= 1'b1;
            end
          end
        end

        S_PGM: begin
          if (!efuse_aen_i) begin
            // Strobe fell: the pulse is complete, judge its width now.
            state <= S_IDLE;
            if (width_cnt >= tpgm_ext) begin
              // One-time programmable: only a 0->1 transition counts.
              if (!fuse_bits_o[addr_q]) begin
                fuse_bits_o[addr_q] <= 1'b1;
                if (pgm_cnt_o != 9'd256) pgm_cnt_o <= pgm_cnt_o + 9'd1;
              end
            end else begin
              err_o[0] <= 1'b1;
            end
          end else if (!efuse_pgmen_i) begin
            state    <= S_IDLE;
            err_o[3] <= 1'b1;
          end else if (!cnt_sat) begin
            width_cnt <= width_cnt + CNT_W'(1);
          end
        end

        S_RD: begin
          if (!efuse_aen_i) begin
            state <= S_IDLE;
            if (width_cnt >= trd_ext) begin
              efuse_rdata_o <= fuse_bits_o[{addr_q[7:3], 3'b000} +: 8];
            end else begin
              efuse_rdata_o <= 8'h00;
              err_o[1]      <= 1'b1;
            end
          end else if (!efuse_rden_i) begin
            state    <= S_IDLE;
            err_o[3] <= 1'b1;
          end else if (!cnt_sat) begin
            width_cnt <= width_cnt + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_macro_model.sv
module tb_efuse_macro_model;

  localparam logic [1:0] M_PGM  = 2'd0;
  localparam logic [1:0] M_RD   = 2'd1;
  localparam logic [1:0] M_BOTH = 2'd2;
  localparam logic [1:0] M_NONE = 2'd3;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] addr;
    int         width;
    logic [9:0] tpgm;
    logic [5:0] trd;
    logic       exp_set;
    logic [7:0] exp_rdata;
    logic [3:0] exp_err;
    logic [8:0] exp_cnt;
    logic       exp_busy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pgmen = 1'b0;
  logic         rden = 1'b0;
  logic         aen = 1'b0;
  logic [7:0]   addr = 8'h00;
  logic [9:0]   tpgm = 10'd0;
  logic [5:0]   trd = 6'd0;
  logic [7:0]   rdata;
  logic [255:0] bits;
  logic [3:0]   err;
  logic [8:0]   cnt;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [255:0] exp_bits = '0;
  vec_t vq[$];

  efuse_macro_model #(.TPGM_W(10), .TRD_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .efuse_pgmen_i (pgmen),
    .efuse_rden_i  (rden),
    .efuse_aen_i   (aen),
    .efuse_addr_i  (addr),
    .cfg_tpgm_min  (tpgm),
    .cfg_trd_min   (trd),
    .efuse_rdata_o (rdata),
    .fuse_bits_o   (bits),
    .err_o         (err),
    .pgm_cnt_o     (cnt),
    .busy_o        (busy),
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard compare
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_rd, input logic [3:0] e_err,
                         input logic [8:0] e_cnt);
    chk({tag, " rdata"}, 256'(rdata), 256'(e_rd));
    chk({tag, " err"},   256'(err),   256'(e_err));
    chk({tag, " cnt"},   256'(cnt),   256'(e_cnt));
    chk({tag, " bits"},  bits,        exp_bits);
    chk({tag, " busy"},  256'(busy),  256'(1'b0));
  endtask

  // Driver: one strobe pulse high for 'width' rising edges; inputs change on negedge.
  task automatic pulse(input vec_t v, input string tag);
    tpgm  = v.tpgm;
    trd   = v.trd;
    addr  = v.addr;
    pgmen = (v.mode == M_PGM) || (v.mode == M_BOTH);
    rden  = (v.mode == M_RD)  || (v.mode == M_BOTH);
    aen   = 1'b1;
    @(negedge clk);
    chk({tag, " busy_in_pulse"}, 256'(busy), 256'(v.exp_busy));
    repeat (v.width - 1) @(negedge clk);
    aen = 1'b0;
    @(negedge clk);
    pgmen = 1'b0;
    rden  = 1'b0;
  endtask

  initial begin
    vq.push_back(vec_t'{M_PGM,  8'h0B, 59, 10'd60,   6'd0, 1'b0, 8'h00, 4'h1, 9'd0, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h0B, 60, 10'd60,   6'd0, 1'b1, 8'h00, 4'h1, 9'd1, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h08,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd2, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h09,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd3, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h0A,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd4, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h0B,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd4, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h0C,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd5, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h0D,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd6, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h0E,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd7, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h0F,  2, 10'd0,    6'd0, 1'b1, 8'h00, 4'h1, 9'd8, 1'b1});
    vq.push_back(vec_t'{M_RD,   8'h08,  9, 10'd0,    6'd9, 1'b0, 8'hFF, 4'h1, 9'd8, 1'b1});
    vq.push_back(vec_t'{M_RD,   8'h08,  8, 10'd0,    6'd9, 1'b0, 8'h00, 4'h3, 9'd8, 1'b1});
    vq.push_back(vec_t'{M_RD,   8'h0D,  1, 10'd0,    6'd0, 1'b0, 8'hFF, 4'h3, 9'd8, 1'b1});
    vq.push_back(vec_t'{M_RD,   8'h00,  3, 10'd0,    6'd0, 1'b0, 8'h00, 4'h3, 9'd8, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h03,  5, 10'd5,    6'd0, 1'b1, 8'h00, 4'h3, 9'd9, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h03,  5, 10'd5,    6'd0, 1'b1, 8'h00, 4'h3, 9'd9, 1'b1});
    vq.push_back(vec_t'{M_RD,   8'h00,  2, 10'd0,    6'd0, 1'b0, 8'h08, 4'h3, 9'd9, 1'b1});
    vq.push_back(vec_t'{M_PGM,  8'h08,  4, 10'd9,    6'd0, 1'b0, 8'h08, 4'h3, 9'd9, 1'b1});
    vq.push_back(vec_t'{M_BOTH, 8'h20,  3, 10'd0,    6'd0, 1'b0, 8'h08, 4'h7, 9'd9, 1'b0});
    vq.push_back(vec_t'{M_NONE, 8'h21,  3, 10'd0,    6'd0, 1'b0, 8'h08, 4'h7, 9'd9, 1'b0});
    vq.push_back(vec_t'{M_PGM,  8'h30,  5, 10'd1023, 6'd0, 1'b0, 8'h08, 4'h7, 9'd9, 1'b1});

    // Reset state
    repeat (3) @(negedge clk);
    chk_all("reset", 8'h00, 4'h0, 9'd0);
    chk("reset state", 256'(dbg_state), 256'(2'd0));
    rst = 1'b0;
    @(negedge clk);

    // Table-driven accesses
    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      pulse(vq[i], tag);
      if (vq[i].exp_set) exp_bits[vq[i].addr] = 1'b1;
      chk_all(tag, vq[i].exp_rdata, vq[i].exp_err, vq[i].exp_cnt);
    end

    // Mode select drops mid-pulse: abort, flag, no array change
    tpgm = 10'd2; addr = 8'h40; pgmen = 1'b1; aen = 1'b1;
    @(negedge clk);
    chk("drop busy_before", 256'(busy), 256'(1'b1));
    @(negedge clk);
    pgmen = 1'b0;
    @(negedge clk);
    chk("drop busy_after", 256'(busy), 256'(1'b0));
    @(negedge clk);
    aen = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("drop", 8'h08, 4'hF, 9'd9);

    // Address change during the pulse uses the latched address
    tpgm = 10'd2; addr = 8'h50; pgmen = 1'b1; aen = 1'b1;
    @(negedge clk);
    addr = 8'h51;
    repeat (3) @(negedge clk);
    aen = 1'b0;
    @(negedge clk);
    pgmen = 1'b0;
    exp_bits[8'h50] = 1'b1;
    chk_all("addr_latch", 8'h08, 4'hF, 9'd10);

    // Threshold is sampled at the falling edge, not at the rise
    tpgm = 10'd100; addr = 8'h52; pgmen = 1'b1; aen = 1'b1;
    repeat (4) @(negedge clk);
    tpgm = 10'd3;
    aen = 1'b0;
    @(negedge clk);
    pgmen = 1'b0;
    exp_bits[8'h52] = 1'b1;
    chk_all("cfg_at_fall", 8'h08, 4'hF, 9'd11);

    // Reset mid-programme, strobe held high across release
    tpgm = 10'd2; addr = 8'h60; pgmen = 1'b1; aen = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid busy_before", 256'(busy), 256'(1'b1));
    rst = 1'b1;
    #1;
    exp_bits = '0;
    chk_all("rstmid", 8'h00, 4'h0, 9'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rstrel busy%0d", k), 256'(busy), 256'(1'b0));
    end
    aen = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("rstrel", 8'h00, 4'h0, 9'd0);
    pgmen = 1'b0;

    // A fresh pulse after the strobe went low works normally
    pulse(vec_t'{M_PGM, 8'h60, 2, 10'd2, 6'd0, 1'b1, 8'h00, 4'h0, 9'd1, 1'b1}, "post_rst");
    exp_bits[8'h60] = 1'b1;
    chk_all("post_rst", 8'h00, 4'h0, 9'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
